// File: rtl/inst_rom_pkg.sv
// Shared wisecore ROM definitions: state encodings, bus width and zero word.
package inst_rom_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ROM_IDLE = 2'd0,
        ROM_LOAD = 2'd1,
        ROM_DONE = 2'd2
    } rom_state_e;
endpackage

// File: rtl/inst_rom_byte_packer.sv
// Assembles loader bytes big-endian into 32-bit words; pulses word_valid_o on the 4th byte.
module rom_byte_packer
    import inst_rom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [INST_W-1:0] word_o
);
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    // Only three bytes need holding; the fourth arrives on byte_i with word_valid_o.
    logic [23:0] shift_q, shift_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clr_i) begin
            byte_cnt_d = '0;
            shift_d    = '0;
        end else if (en_i) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = en_i && !clr_i && (byte_cnt_q == 2'd3);
endmodule

// File: rtl/inst_rom.sv
// Instruction ROM for wisecore: combinational fetch port plus a byte-stream program loader
// that holds the core in reset while loading.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ce,
    input  logic [31:0]       i_pc,
    output logic [INST_W-1:0] o_inst,
    input  logic              i_ld_start,
    input  logic [LEN_W-1:0]  i_ld_len,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_byte,
    output logic              o_ld_ready,
    output logic              o_ld_busy,
    output logic              o_ld_done,
    output logic              o_core_rst,
    output logic              o_addr_err
);
    localparam int DEPTH = 2 ** ADDR_W;

    rom_state_e         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic               err_q, err_d;
    logic               start_acc;
    logic               byte_xfer;
    logic               word_valid;
    logic [INST_W-1:0]  word;
    logic               in_range;
    logic [INST_W-1:0]  mem [0:DEPTH-1];

    assign byte_xfer = i_ld_valid && o_ld_ready;

    rom_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start_acc),
        .en_i        (byte_xfer),
        .byte_i      (i_ld_byte),
        .word_valid_o(word_valid),
        .word_o      (word)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        wptr_d    = wptr_q;
        start_acc = 1'b0;
        case (state_q)
            ROM_IDLE: begin
                if (i_ld_start) begin
                    start_acc = 1'b1;
                    if (i_ld_len != '0) begin
                        len_d   = i_ld_len;
                        wcnt_d  = '0;
                        wptr_d  = '0;
                        state_d = ROM_LOAD;
                    end else begin
                        state_d = ROM_DONE;
                    end
                end
            end
            ROM_LOAD: begin
                if (word_valid) begin
                    wptr_d = wptr_q + ADDR_W'(1);
                    wcnt_d = wcnt_q + LEN_W'(1);
                    if (wcnt_q + LEN_W'(1) == len_q) state_d = ROM_DONE;
                end
            end
            ROM_DONE: state_d = ROM_IDLE;
            default:  state_d = ROM_IDLE;
        endcase
    end

    assign in_range = (i_pc[31:ADDR_W+2] == '0);

    // A new load wipes the error history along with the program.
    always_comb begin
        err_d = err_q;
        if (start_acc)
            err_d = 1'b0;
        else if (i_ce && (!in_range || i_pc[1:0] != 2'b00))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ROM_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            wptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset so a partial load survives a core reset.
    always_ff @(posedge clk) begin
        if (word_valid && !rst) mem[wptr_q] <= word;
    end

    always_comb begin
        o_inst = ZERO_WORD;
        if (!rst && i_ce && in_range) o_inst = mem[i_pc[ADDR_W+1:2]];
    end

    assign o_ld_ready = (state_q == ROM_LOAD);
    assign o_ld_busy  = (state_q == ROM_LOAD);
    assign o_ld_done  = (state_q == ROM_DONE);
    assign o_core_rst = rst || (state_q != ROM_IDLE);
    assign o_addr_err = err_q;
endmodule

// File: tb/tb_inst_rom.sv
// Directed + randomized bench for inst_rom against a word-array reference model.
module tb_inst_rom;
    logic        clk, rst, i_ce, i_ld_start, i_ld_valid;
    logic [31:0] i_pc;
    logic [15:0] i_ld_len;
    logic [7:0]  i_ld_byte;
    logic [31:0] o_inst;
    logic        o_ld_ready, o_ld_busy, o_ld_done, o_core_rst, o_addr_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          xfers = 0;
    logic [31:0] model_mem [1024];
    logic [31:0] wq [$];

    inst_rom #(.ADDR_W(10), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .i_ce(i_ce), .i_pc(i_pc), .o_inst(o_inst),
        .i_ld_start(i_ld_start), .i_ld_len(i_ld_len), .i_ld_valid(i_ld_valid),
        .i_ld_byte(i_ld_byte), .o_ld_ready(o_ld_ready), .o_ld_busy(o_ld_busy),
        .o_ld_done(o_ld_done), .o_core_rst(o_core_rst), .o_addr_err(o_addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (i_ld_valid && o_ld_ready) xfers++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc);
        i_ce = 1'b1;
        i_pc = pc;
        #1;
        chk(tag, o_inst, (pc[31:12] == 0) ? model_mem[pc[11:2]] : 32'h0);
        i_ce = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_ld_valid = 1'b1;
        i_ld_byte  = b;
        tick();
        i_ld_valid = 1'b0;
    endtask

    // Loads the words in wq; model writes word n to address n mod 1024.
    task automatic load(input int len, input bit stalls, input bit mid_start);
        logic [31:0] wd;
        i_ld_len   = 16'(len);
        i_ld_start = 1'b1;
        tick();
        i_ld_start = 1'b0;
        for (int w = 0; w < len; w++) begin
            wd = wq[w];
            for (int b = 0; b < 4; b++) begin
                if (stalls)
                    for (int k = $urandom_range(0, 3); k > 0; k--) tick();
                if (mid_start && w == 1 && b == 0) begin
                    i_ld_start = 1'b1;
                    i_ld_len   = 16'd5;
                    tick();
                    i_ld_start = 1'b0;
                end
                send_byte(wd[31-8*b -: 8]);
            end
            model_mem[w % 1024] = wd;
        end
    endtask

    task automatic finish_load(input string tag);
        chk({tag, "_done"}, 32'(o_ld_done), 32'd1);
        chk({tag, "_rdy_done"}, 32'(o_ld_ready), 32'd0);
        chk({tag, "_crst_done"}, 32'(o_core_rst), 32'd1);
        tick();
        chk({tag, "_done_end"}, 32'(o_ld_done), 32'd0);
        chk({tag, "_crst_idle"}, 32'(o_core_rst), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_ce = 1'b1; i_pc = 32'h0; i_ld_start = 1'b0;
        i_ld_len = '0; i_ld_valid = 1'b0; i_ld_byte = '0;
        tick();
        tick();
        chk("rst_core_rst", 32'(o_core_rst), 32'd1);
        chk("rst_ready", 32'(o_ld_ready), 32'd0);
        chk("rst_err", 32'(o_addr_err), 32'd0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_done", 32'(o_ld_done), 32'd0);
        rst = 1'b0; i_ce = 1'b0;
        tick();
        chk("idle_core_rst", 32'(o_core_rst), 32'd0);

        // Two fixed words
        wq = '{32'h34010010, 32'h24020020};
        load(2, 1'b0, 1'b0);
        finish_load("ld2");
        chk("ld2_word0", model_mem[0], 32'h34010010);
        fetch("fetch_pc0", 32'h0);
        fetch("fetch_pc4", 32'h4);
        chk("fetch_pc0_lit", model_mem[0], 32'h34010010);
        i_ce = 1'b0; i_pc = 32'h0; #1;
        chk("fetch_ce0", o_inst, 32'h0);

        // Three random words with stalls and an ignored mid-load start
        wq = '{$urandom, $urandom, $urandom};
        xfers = 0;
        load(3, 1'b1, 1'b1);
        chk("stall_xfers", 32'(xfers), 32'd12);
        finish_load("ld3");
        fetch("ld3_w0", 32'h0);
        fetch("ld3_w1", 32'h4);
        fetch("ld3_w2", 32'h8);
        chk("err_clean", 32'(o_addr_err), 32'd0);

        // Misaligned fetch reads the aligned word and flags an error
        i_ce = 1'b1; i_pc = 32'h6; #1;
        chk("misalign_inst", o_inst, model_mem[1]);
        tick();
        i_ce = 1'b0;
        chk("misalign_err", 32'(o_addr_err), 32'd1);
        i_ce = 1'b1; i_pc = 32'h2;
        tick();
        i_ce = 1'b0;
        chk("pc2_err_sticky", 32'(o_addr_err), 32'd1);

        // Zero-length load: done pulse, no writes, error cleared
        wq = {};
        load(0, 1'b0, 1'b0);
        chk("len0_err_clr", 32'(o_addr_err), 32'd0);
        finish_load("len0");
        fetch("len0_w0", 32'h0);
        fetch("len0_w1", 32'h4);

        // Out-of-range fetch
        i_ce = 1'b0; i_pc = 32'h1000;
        tick();
        chk("oor_ce0_noerr", 32'(o_addr_err), 32'd0);
        i_ce = 1'b1; #1;
        chk("oor_inst", o_inst, 32'h0);
        tick();
        i_ce = 1'b0;
        chk("oor_err", 32'(o_addr_err), 32'd1);

        // 1025 words: last word wraps onto word 0
        wq = {};
        for (int i = 0; i < 1025; i++) wq.push_back($urandom);
        load(1025, 1'b0, 1'b0);
        chk("wrap_err_clr", 32'(o_addr_err), 32'd0);
        finish_load("wrap");
        chk("wrap_model", model_mem[0], wq[1024]);
        fetch("wrap_w0", 32'h0);
        fetch("wrap_w1", 32'h4);
        fetch("wrap_w511", 32'h7FC);
        fetch("wrap_w1023", 32'hFFC);

        // Reset after 5 bytes: word 0 kept, no done pulse
        wq = '{$urandom, $urandom};
        i_ld_len = 16'd2; i_ld_start = 1'b1;
        tick();
        i_ld_start = 1'b0;
        for (int b = 0; b < 4; b++) send_byte(wq[0][31-8*b -: 8]);
        model_mem[0] = wq[0];
        send_byte(wq[1][31:24]);
        rst = 1'b1;
        tick();
        chk("mrst_ready", 32'(o_ld_ready), 32'd0);
        chk("mrst_busy", 32'(o_ld_busy), 32'd0);
        chk("mrst_done", 32'(o_ld_done), 32'd0);
        chk("mrst_crst", 32'(o_core_rst), 32'd1);
        rst = 1'b0;
        tick();
        chk("mrst_done2", 32'(o_ld_done), 32'd0);
        chk("mrst_crst_idle", 32'(o_core_rst), 32'd0);
        fetch("mrst_w0", 32'h0);
        fetch("mrst_w1_old", 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
